cfu_simd_mac: RTL and testbench
===============================

Name: cfu_simd_mac

Overview:
Parametrised SIMD multiply-accumulate custom function unit for the int8/int16 convolution inner loop. Each 32-bit operand word is split into LANES = 32/LANE_W signed lanes. Per-lane offsets are added, the lane pairs are multiplied, the lane products are reduced, and the result is added into a persistent accumulator. It sits on the CPU CFU command/response port, uses a pipelined datapath of configurable depth, and accepts one command in flight.

Parameters:
LANE_W, 8, lane width in bits; legal values 8 or 16; LANES = 32/LANE_W.
OFFSET_W, 9, width of the signed InputOffset/FilterOffset registers.
ACC_W, 32, accumulator width; legal range 16..32; wraps modulo 2^ACC_W.
PIPE_STAGES, 2, datapath latency in cycles from command accept to rsp_valid; legal range 1..4.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept a command.
cmd_payload_function_id  in  10  [2:0]=funct3 (operation), [9:3]=funct7 (modifiers).
cmd_payload_inputs_0  in  32  packed input-activation lanes, or write data.
cmd_payload_inputs_1  in  32  packed filter lanes.
rsp_valid  out  1  response present.
rsp_ready  in  1  CPU accepts the response.
rsp_payload_outputs_0  out  32  result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rsp_valid=0, rsp_payload_outputs_0=0, acc=0, InputOffset=0, FilterOffset=0, pipeline valid bits cleared. Any in-flight command is discarded with no response. cmd_ready=0 while reset is asserted.
- States: IDLE, EXEC, RESP. cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid & cmd_ready, latch the operands and funct fields and go to EXEC.
- EXEC: counts PIPE_STAGES-1 further cycles, then goes to RESP. With PIPE_STAGES=1, EXEC lasts 0 extra cycles and the block goes directly to RESP.
- RESP: rsp_valid=1; payload is stable until the handshake. On rsp_ready go to IDLE; rsp_valid drops the next cycle. rsp_ready may be held high permanently. At full throughput a new command is accepted every PIPE_STAGES+1 cycles.
- funct3 encodings:
  - 0 SET_IOFF: InputOffset <= inputs_0[OFFSET_W-1:0]; response = 0.
  - 1 SET_FOFF: FilterOffset <= inputs_0[OFFSET_W-1:0]; response = 0.
  - 2 MAC: acc <= base + dot; response = new acc value. base = 0 if funct7[0]=1, otherwise the current acc.
  - 3 DOT: response = dot; acc unchanged.
  - 4 READ_ACC: response = acc. If funct7[0]=1, also acc <= 0.
  - 5 WRITE_ACC: acc <= inputs_0[ACC_W-1:0]; response = 0.
  - 6, 7: no state change; response = 0xFFFFFFFF.
- Lane arithmetic:
  - Lane i = bits [i*LANE_W +: LANE_W], signed. If funct7[1]=1, lanes are treated as unsigned (zero-extended).
  - a_i = lane0_i + InputOffset and b_i = lane1_i + FilterOffset, each computed at max(LANE_W+1, OFFSET_W)+1 bits with no overflow.
  - p_i = a_i*b_i at full width.
  - dot = sum of p_i, sign-extended to ACC_W, then wrapped to ACC_W.
- Output width: acc-derived and dot responses are sign-extended from ACC_W to 32 bits.
- Register update timing: offset and acc registers update on the cycle the block enters RESP. Any later command sees the updated values.
- Boundary conditions:
  - MAC with funct7[0]=1 ignores the prior acc.
  - acc overflow wraps silently.
  - cmd_valid arriving during EXEC or RESP is ignored and stalled by cmd_ready=0; it is not lost by the CPU.
  - reset asserted in RESP clears rsp_valid asynchronously.

Test Plan:
1. LANE_W=8, offsets 0: MAC (funct7[0]=1) with in0=0x01020304, in1=0x01010101 -> response 10, arriving exactly PIPE_STAGES cycles after accept; then READ_ACC -> 10.
2. SET_IOFF 128, then DOT with in0=0x80808080 (all lanes -128), in1=0x02020202 -> 0; then MAC with in0=0x7F7F7F7F, in1=0x7F7F7F7F -> 4*255*127=129540.
3. Signed extremes: MAC(clear) with in0=0x80808080, in1=0x80808080 -> 65536; same operands with funct7[1]=1 (unsigned) -> 65536; then in0=0xFF000000, in1=0x01000000 -> signed -1, unsigned 255.
4. ACC_W=16: WRITE_ACC 0x7FFF, then MAC with in0=0x00000001, in1=0x00000001 -> response 0xFFFF8000; READ_ACC with clear -> 0xFFFF8000, and a following READ_ACC -> 0.
5. Handshake: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and payload stable and cmd_ready=0 throughout; cmd_valid held high during this time is accepted only after the response handshake.
6. LANE_W=16: MAC(clear) with in0=0xFFFF0002, in1=0x00030004 -> -3+8=5. Assert reset mid-EXEC -> no response is produced; afterwards READ_ACC -> 0 and the offsets are 0.

Source files
------------

// File: rtl/cfu_simd_mac.sv
// SIMD multiply-accumulate CFU: offset-adjusted lane products are summed into a
// wrapping accumulator behind a single-command CFU request/response handshake.

module cfu_simd_mac_lane #(
    parameter int LANE_W   = 8,
    parameter int OFFSET_W = 9,
    parameter int ACC_W    = 32
) (
    input  logic [LANE_W-1:0]   lane0,
    input  logic [LANE_W-1:0]   lane1,
    input  logic                uns,
    input  logic [OFFSET_W-1:0] ioff,
    input  logic [OFFSET_W-1:0] foff,
    output logic [ACC_W-1:0]    prod
);
    logic signed [LANE_W:0]  x0, x1;
    logic signed [ACC_W-1:0] a, b;

    assign x0 = {lane0[LANE_W-1] & ~uns, lane0};
    assign x1 = {lane1[LANE_W-1] & ~uns, lane1};

    // The reduced result wraps to ACC_W, so arithmetic modulo 2^ACC_W is exact here.
    assign a    = ACC_W'(x0) + ACC_W'($signed(ioff));
    assign b    = ACC_W'(x1) + ACC_W'($signed(foff));
    assign prod = a * b;
endmodule

module cfu_simd_mac #(
    parameter int LANE_W      = 8,
    parameter int OFFSET_W    = 9,
    parameter int ACC_W       = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);
    localparam int LANES = 32 / LANE_W;
    localparam int TAP   = (PIPE_STAGES >= 2) ? PIPE_STAGES - 2 : 0;
    localparam bit SHORT = (PIPE_STAGES == 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic        clr;
        logic        uns;
        logic [31:0] in0;
        logic [31:0] in1;
    } req_t;

    state_t                      state, next;
    req_t                        req_live, req_q, req;
    logic [TAP:0]                vld_pipe;
    logic [ACC_W-1:0]            acc, acc_n, dot;
    logic [OFFSET_W-1:0]         ioff, foff, ioff_n, foff_n;
    logic [31:0]                 res, rsp_data;
    logic [LANES-1:0][ACC_W-1:0] prod;
    logic                        accept, commit;
    logic                        unused_fid;

    function automatic logic [31:0] sext(input logic [ACC_W-1:0] v);
        return 32'($signed(v));
    endfunction

    assign req_live = '{f3:  cmd_payload_function_id[2:0],
                        clr: cmd_payload_function_id[3],
                        uns: cmd_payload_function_id[4],
                        in0: cmd_payload_inputs_0,
                        in1: cmd_payload_inputs_1};
    assign unused_fid = ^cmd_payload_function_id[9:5];

    assign cmd_ready = (state == IDLE) & reset;
    assign rsp_valid = (state == RESP);
    assign rsp_payload_outputs_0 = rsp_data;
    assign accept    = cmd_valid & cmd_ready;

    // A single-stage unit computes straight from the port on the accept edge.
    assign req    = (state == IDLE) ? req_live : req_q;
    assign commit = ((state == EXEC) && vld_pipe[TAP]) || (SHORT && accept);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cfu_simd_mac_lane #(.LANE_W(LANE_W), .OFFSET_W(OFFSET_W), .ACC_W(ACC_W)) u_lane (
            .lane0 (req.in0[i*LANE_W +: LANE_W]),
            .lane1 (req.in1[i*LANE_W +: LANE_W]),
            .uns   (req.uns),
            .ioff  (ioff),
            .foff  (foff),
            .prod  (prod[i])
        );
    end

    always_comb begin
        dot = '0;
        for (int i = 0; i < LANES; i++) dot = dot + prod[i];
    end

    always_comb begin
        acc_n  = acc;
        ioff_n = ioff;
        foff_n = foff;
        res    = '0;
        unique case (req.f3)
            3'd0: ioff_n = req.in0[OFFSET_W-1:0];
            3'd1: foff_n = req.in0[OFFSET_W-1:0];
            3'd2: begin
                acc_n = (req.clr ? '0 : acc) + dot;
                res   = sext(acc_n);
            end
            3'd3: res = sext(dot);
            3'd4: begin
                res = sext(acc);
                if (req.clr) acc_n = '0;
            end
            3'd5: acc_n = req.in0[ACC_W-1:0];
            default: res = '1;
        endcase
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (accept) next = SHORT ? RESP : EXEC;
            EXEC: if (vld_pipe[TAP]) next = RESP;
            RESP: if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            vld_pipe <= '0;
            req_q    <= '0;
            acc      <= '0;
            ioff     <= '0;
            foff     <= '0;
            rsp_data <= '0;
        end else begin
            state    <= next;
            vld_pipe <= (vld_pipe << 1) | (TAP + 1)'(accept);
            if (accept) req_q <= req_live;
            if (commit) begin
                acc      <= acc_n;
                ioff     <= ioff_n;
                foff     <= foff_n;
                rsp_data <= res;
            end
        end
    end
endmodule

// File: tb/tb_cfu_simd_mac.sv
// Bench for cfu_simd_mac: three configurations share the command bus; results are
// checked against spec vectors and an integer-arithmetic reference model.

module tb_cfu_simd_mac;
    localparam int LW [3] = '{8, 16, 8};
    localparam int AW [3] = '{32, 16, 32};
    localparam int PS [3] = '{2, 3, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  fid;
    logic [31:0] in0, in1;
    logic        rsp_ready;
    logic        cmd_valid [3];
    logic        cmd_ready [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_data  [3];

    always #5 clk = ~clk;

    cfu_simd_mac #(.LANE_W(8), .OFFSET_W(9), .ACC_W(32), .PIPE_STAGES(2)) u_d0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data[0]));

    cfu_simd_mac #(.LANE_W(16), .OFFSET_W(9), .ACC_W(16), .PIPE_STAGES(3)) u_d1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data[1]));

    cfu_simd_mac #(.LANE_W(8), .OFFSET_W(9), .ACC_W(32), .PIPE_STAGES(1)) u_d2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_payload_function_id(fid), .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_data[2]));

    int     n_chk = 0, n_fail = 0;
    longint m_acc [3], m_ioff [3], m_foff [3];

    typedef struct {
        int          d;
        logic [9:0]  f;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vt [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no handshake within cycle budget", nm);
    endtask

    function automatic longint wrap(input longint x, input int w);
        longint one = 1, m;
        m = x & ((one << w) - 1);
        if (m >= (one << (w - 1))) m = m - (one << w);
        return m;
    endfunction

    function automatic longint lane_val(input logic [31:0] w, input int i, input int lw, input bit uns);
        longint one = 1, v;
        v = longint'(w >> (i * lw)) & ((one << lw) - 1);
        if (!uns && v >= (one << (lw - 1))) v = v - (one << lw);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0; m_ioff[d] = 0; m_foff[d] = 0;
        end
    endtask

    task automatic model(input int d, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res);
        longint dot = 0;
        for (int i = 0; i < 32 / LW[d]; i++)
            dot += (lane_val(a, i, LW[d], f[4]) + m_ioff[d]) * (lane_val(b, i, LW[d], f[4]) + m_foff[d]);
        res = 32'h0;
        case (f[2:0])
            3'd0: m_ioff[d] = wrap(longint'(a), 9);
            3'd1: m_foff[d] = wrap(longint'(a), 9);
            3'd2: begin
                m_acc[d] = wrap((f[3] ? 64'sd0 : m_acc[d]) + dot, AW[d]);
                res = 32'(m_acc[d]);
            end
            3'd3: res = 32'(wrap(dot, AW[d]));
            3'd4: begin
                res = 32'(m_acc[d]);
                if (f[3]) m_acc[d] = 0;
            end
            3'd5: m_acc[d] = wrap(longint'(a), AW[d]);
            default: res = 32'hFFFF_FFFF;
        endcase
    endtask

    task automatic do_cmd(input int d, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        int t = 0;
        @(negedge clk);
        fid = f; in0 = a; in1 = b; rsp_ready = 1'b1; cmd_valid[d] = 1'b1;
        while (!cmd_ready[d] && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) timeout("accept");
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid[d]) timeout("response");
        r = rsp_data[d];
    endtask

    task automatic run(input string nm, input int d, input logic [9:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit use_exp, input logic [31:0] exp_v);
        logic [31:0] m, r;
        int lat;
        model(d, f, a, b, m);
        do_cmd(d, f, a, b, r, lat);
        chk(nm, r, use_exp ? exp_v : m);
        chk({nm, "_latency"}, 32'(lat), 32'(PS[d]));
    endtask

    task automatic add(input int d, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
        vec_t v;
        v.d = d; v.f = f; v.a = a; v.b = b; v.exp = e;
        vt.push_back(v);
    endtask

    initial begin
        logic [31:0] e1, e2;
        int t;
        bit  seen;

        // {device, function_id, in0, in1, expected}; bit3 = clear/base-0, bit4 = unsigned
        add(0, 10'h00A, 32'h01020304, 32'h01010101, 32'd10);
        add(0, 10'h004, 32'h0,        32'h0,        32'd10);
        add(0, 10'h000, 32'd128,      32'h0,        32'd0);
        add(0, 10'h003, 32'h80808080, 32'h02020202, 32'd0);
        add(0, 10'h00A, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'd129540);
        add(0, 10'h000, 32'h0,        32'h0,        32'd0);
        add(0, 10'h00A, 32'h80808080, 32'h80808080, 32'd65536);
        add(0, 10'h01A, 32'h80808080, 32'h80808080, 32'd65536);
        add(0, 10'h00A, 32'hFF000000, 32'h01000000, 32'hFFFFFFFF);
        add(0, 10'h01A, 32'hFF000000, 32'h01000000, 32'd255);
        add(0, 10'h001, 32'h1FF,      32'h0,        32'd0);
        add(0, 10'h003, 32'h01010101, 32'h01010101, 32'd0);
        add(0, 10'h003, 32'h01010101, 32'h03030303, 32'd8);
        add(0, 10'h001, 32'h0,        32'h0,        32'd0);
        add(0, 10'h006, 32'h1,        32'h1,        32'hFFFFFFFF);
        add(0, 10'h007, 32'h1,        32'h1,        32'hFFFFFFFF);
        add(0, 10'h004, 32'h0,        32'h0,        32'd255);
        add(0, 10'h005, 32'h7FFFFFFF, 32'h0,        32'd0);
        add(0, 10'h002, 32'h1,        32'h1,        32'h80000000);
        add(0, 10'h00C, 32'h0,        32'h0,        32'h80000000);
        add(0, 10'h004, 32'h0,        32'h0,        32'd0);
        add(1, 10'h005, 32'h7FFF,     32'h0,        32'd0);
        add(1, 10'h002, 32'h1,        32'h1,        32'hFFFF8000);
        add(1, 10'h00C, 32'h0,        32'h0,        32'hFFFF8000);
        add(1, 10'h004, 32'h0,        32'h0,        32'd0);
        add(1, 10'h00A, 32'hFFFF0002, 32'h00030004, 32'd5);
        add(2, 10'h00A, 32'h01020304, 32'h01010101, 32'd10);
        add(2, 10'h004, 32'h0,        32'h0,        32'd10);

        reset = 1'b0; fid = '0; in0 = '0; in1 = '0; rsp_ready = 1'b1;
        foreach (cmd_valid[i]) cmd_valid[i] = 1'b0;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset_payload", rsp_data[d], 32'd0);
            chk("reset_cmd_ready", 32'(cmd_ready[d]), 32'd0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready[0]), 32'd1);

        for (int i = 0; i < vt.size(); i++)
            run($sformatf("vec%0d", i), vt[i].d, vt[i].f, vt[i].a, vt[i].b, 1'b1, vt[i].exp);

        // Response back-pressure with a second command waiting on the bus
        model(0, 10'h00A, 32'h01020304, 32'h01010101, e1);
        model(0, 10'h002, 32'h01010101, 32'h01010101, e2);
        @(negedge clk);
        fid = 10'h00A; in0 = 32'h01020304; in1 = 32'h01010101; rsp_ready = 1'b0; cmd_valid[0] = 1'b1;
        @(negedge clk);
        fid = 10'h002; in0 = 32'h01010101; in1 = 32'h01010101;
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        for (int k = 0; k < 5; k++) begin
            chk("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
            chk("stall_payload", rsp_data[0], e1);
            chk("stall_cmd_ready", 32'(cmd_ready[0]), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("after_hs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("after_hs_cmd_ready", 32'(cmd_ready[0]), 32'd1);
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        chk("queued_cmd_result", rsp_data[0], e2);

        // Reset while holding a response
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        fid = 10'h00A; in0 = 32'h01020304; in1 = 32'h01010101; cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (!rsp_valid[0] && t < 20) begin @(negedge clk); t++; end
        chk("resp_before_reset", 32'(rsp_valid[0]), 32'd1);
        reset = 1'b0;
        #1;
        chk("resp_reset_valid", 32'(rsp_valid[0]), 32'd0);
        chk("resp_reset_payload", rsp_data[0], 32'd0);
        chk("resp_reset_cmd_ready", 32'(cmd_ready[0]), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of EXEC on the 3-stage unit, with offsets and acc non-zero
        run("pre_ioff", 1, 10'h000, 32'd5, 32'h0, 1'b1, 32'd0);
        run("pre_foff", 1, 10'h001, 32'd3, 32'h0, 1'b1, 32'd0);
        run("pre_wacc", 1, 10'h005, 32'd100, 32'h0, 1'b1, 32'd0);
        run("pre_dot", 1, 10'h003, 32'h0, 32'h0, 1'b1, 32'd30);
        @(negedge clk);
        fid = 10'h002; in0 = 32'h00010001; in1 = 32'h00010001; cmd_valid[1] = 1'b1;
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("exec_reset_cmd_ready", 32'(cmd_ready[1]), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid[1]) seen = 1'b1;
        end
        chk("exec_reset_no_response", 32'(seen), 32'd0);
        run("post_reset_acc", 1, 10'h004, 32'h0, 32'h0, 1'b1, 32'd0);
        run("post_reset_offsets", 1, 10'h003, 32'h0, 32'h0, 1'b1, 32'd0);
        run("post_reset_acc_d0", 0, 10'h004, 32'h0, 32'h0, 1'b1, 32'd0);

        for (int k = 0; k < 300; k++) begin
            int d;
            d = int'($urandom_range(0, 2));
            run($sformatf("rand%0d_d%0d", k, d), d, 10'($urandom), $urandom, $urandom, 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
